// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch synchroniser, stability-counter debouncer and edge pulse generator
module sw_debounce #(
  parameter int p_width  = 10,
  parameter int p_stable = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_sw,
  output logic [p_width-1:0] o_level,
  output logic [p_width-1:0] o_rise,
  output logic [p_width-1:0] o_fall,
  output logic [p_width-1:0] o_toggle,
  output logic               o_any
);

  localparam int              c_cw   = $clog2(p_stable + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(p_stable - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  logic [p_width-1:0] sync1;
  logic [p_width-1:0] sync2;
  logic [c_cw-1:0]    cnt_q    [p_width];
  logic [c_cw-1:0]    cnt_next [p_width];
  logic [p_width-1:0] level_next;
  logic [p_width-1:0] rise_next;
  logic [p_width-1:0] fall_next;
  logic [p_width-1:0] toggle_next;

  // Only sync2 is observed downstream; the raw input never touches combinational logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_sw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    level_next = o_level;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < p_width; i++) begin
      cnt_next[i] = '0;
    end
    // Any sample matching the current level restarts the stability window.
    for (int i = 0; i < p_width; i++) begin
      if (sync2[i] != o_level[i]) begin
        if (cnt_q[i] == c_last) begin
          level_next[i] = sync2[i];
          rise_next[i]  = sync2[i];
          fall_next[i]  = ~sync2[i];
        end else begin
          cnt_next[i] = cnt_q[i] + c_one;
        end
      end
    end
    toggle_next = rise_next | fall_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < p_width; i++) begin
        cnt_q[i] <= '0;
      end
      o_level  <= '0;
      o_rise   <= '0;
      o_fall   <= '0;
      o_toggle <= '0;
      o_any    <= 1'b0;
    end else begin
      for (int i = 0; i < p_width; i++) begin
        cnt_q[i] <= cnt_next[i];
      end
      o_level  <= level_next;
      o_rise   <= rise_next;
      o_fall   <= fall_next;
      o_toggle <= toggle_next;
      o_any    <= |toggle_next;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - randomized and directed bench for sw_debounce against a sample-window model
module tb_sw_debounce;
  localparam int P = 4;
  localparam int W = 2;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [W-1:0] i_sw  = '0;
  logic [W-1:0] o_level, o_rise, o_fall, o_toggle;
  logic         o_any;

  int n_chk = 0;
  int n_err = 0;

  sw_debounce #(.p_width(W), .p_stable(P)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sw(i_sw),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_toggle(o_toggle), .o_any(o_any)
  );

  always #5 i_clk = ~i_clk;

  // Model: level flips when the last P decision samples all differ from it
  // and no flip happened within those P edges.
  logic [W-1:0] samp [$];
  logic [W-1:0] dh   [$];
  int           since [W];
  logic [W-1:0] m_level, m_rise, m_fall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    dh.delete();
    for (int b = 0; b < W; b++) since[b] = P;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] d;
    logic         all_diff;
    samp.push_back(i_sw);
    d = (samp.size() >= 3) ? samp[samp.size()-3] : '0;
    dh.push_back(d);
    if (samp.size() > 8) void'(samp.pop_front());
    if (dh.size() > 8) void'(dh.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < W; b++) begin
      since[b]++;
      if (since[b] >= P && dh.size() >= P) begin
        all_diff = 1'b1;
        for (int j = 1; j <= P; j++)
          if (dh[dh.size()-j][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) m_rise[b] = 1'b1;
          else            m_fall[b] = 1'b1;
          since[b] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("level",  32'(o_level),  32'(m_level));
    chk("rise",   32'(o_rise),   32'(m_rise));
    chk("fall",   32'(o_fall),   32'(m_fall));
    chk("toggle", 32'(o_toggle), 32'(m_rise | m_fall));
    chk("any",    32'(o_any),    32'(|(m_rise | m_fall)));
  endtask

  task automatic step(input logic [W-1:0] sw);
    i_sw = sw;
    @(posedge i_clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset between edges, confirm the asynchronous clear, hold across one edge.
  task automatic pulse_reset(input logic [W-1:0] sw);
    i_sw = sw;
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_async", {o_level, o_rise, o_fall, o_toggle, 23'd0, o_any}, 32'd0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int lat;
    int rises;
    model_reset();
    #3;
    chk("reset_state", {o_level, o_rise, o_fall, o_toggle, 23'd0, o_any}, 32'd0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) step(2'b00);

    // Clean rise: first o_rise[0] expected 5 edges after the sampling edge.
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      step(2'b01);
      if (o_rise[0] && lat < 0) lat = k;
    end
    chk("rise_latency", 32'(lat), 32'd5);

    // Bounce on bit 1, then hold high.
    lat = -1;
    rises = 0;
    step(2'b11); step(2'b01); step(2'b11); step(2'b11); step(2'b01);
    for (int k = 0; k < 10; k++) begin
      step(2'b11);
      if (o_rise[1]) begin rises++; if (lat < 0) lat = k; end
    end
    chk("bounce_rises", 32'(rises), 32'd1);
    chk("bounce_latency", 32'(lat), 32'd5);

    // Short glitch on bit 1 must not disturb the level.
    for (int k = 0; k < 3; k++) step(2'b01);
    for (int k = 0; k < 8; k++) step(2'b11);
    chk("glitch_level", 32'(o_level), 32'd3);

    // Both fall together, then both rise together, then bit 0 alone falls.
    for (int k = 0; k < 8; k++) step(2'b00);
    for (int k = 0; k < 8; k++) step(2'b11);
    for (int k = 0; k < 8; k++) step(2'b10);

    // Reset mid-count with bit 0 held high: exactly one rise afterwards.
    pulse_reset(2'b00);
    for (int k = 0; k < 4; k++) step(2'b00);
    step(2'b01); step(2'b01); step(2'b01); step(2'b01);
    pulse_reset(2'b01);
    lat = -1;
    rises = 0;
    for (int k = 0; k < 12; k++) begin
      step(2'b01);
      if (o_rise[0]) begin rises++; if (lat < 0) lat = k; end
    end
    chk("rst_mid_rises", 32'(rises), 32'd1);
    chk("rst_mid_latency", 32'(lat), 32'd5);

    // Reset with inputs low keeps everything at zero.
    pulse_reset(2'b00);
    for (int k = 0; k < 10; k++) step(2'b00);
    chk("idle_after_rst", {o_level, o_rise, o_fall, o_toggle, 23'd0, o_any}, 32'd0);

    // Randomized: hold runs of random length with occasional single-cycle bounces.
    for (int k = 0; k < 1500; k++) begin
      logic [W-1:0] v;
      v = i_sw;
      if ($urandom_range(0, 5) == 0) v = W'($urandom);
      if ($urandom_range(0, 300) == 0) pulse_reset(v);
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
